// File: rtl/cu_pkg.sv
// Shared encodings for the EC-1 control unit: state codes, opcodes and
// accumulator source selects as DataPath expects them.
package cu_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned ASEL_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    S_START  = 4'b0000,
    S_FETCH  = 4'b0001,
    S_DECODE = 4'b0010,
    S_LOAD   = 4'b1000,
    S_STORE  = 4'b1001,
    S_ADD    = 4'b1010,
    S_SUB    = 4'b1011,
    S_INPUT  = 4'b1100,
    S_JZ     = 4'b1101,
    S_JPOS   = 4'b1110,
    S_HALT   = 4'b1111
  } state_e;

  localparam logic [OP_W-1:0] OP_LOAD  = 3'b000;
  localparam logic [OP_W-1:0] OP_STORE = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD   = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB   = 3'b011;
  localparam logic [OP_W-1:0] OP_INPUT = 3'b100;
  localparam logic [OP_W-1:0] OP_JZ    = 3'b101;
  localparam logic [OP_W-1:0] OP_JPOS  = 3'b110;
  localparam logic [OP_W-1:0] OP_HALT  = 3'b111;

  localparam logic [ASEL_W-1:0] ASEL_ALU = 2'd0;
  localparam logic [ASEL_W-1:0] ASEL_IN  = 2'd1;
  localparam logic [ASEL_W-1:0] ASEL_RAM = 2'd2;

  // Execute states sit at 1xxx with the opcode in the low three bits.
  function automatic state_e exec_state(input logic [OP_W-1:0] op);
    return state_e'({1'b1, op});
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Two-stage register on a level input; rise_c pulses for one cycle when the
// first stage is high and the second still low.
module edge_detect (
  input  logic clk,
  input  logic clear,
  input  logic level,
  output logic rise_c
);

  logic in_q, in_d;
  logic in_prev_q, in_prev_d;

  always_comb begin
    in_d      = level;
    in_prev_d = in_q;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      in_q      <= 1'b0;
      in_prev_q <= 1'b0;
    end else begin
      in_q      <= in_d;
      in_prev_q <= in_prev_d;
    end
  end

  assign rise_c = in_q & ~in_prev_q;

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute controller for the EC-1 DataPath. Controls decode from
// the registered state; only PCload in JZ/JPOS follows the flags directly.
module control_unit
  import cu_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic [OP_W-1:0]   IR75,
  input  logic              Aeq0,
  input  logic              Apos,
  input  logic              Enter,
  output logic              IRload,
  output logic              JMPmux,
  output logic              PCload,
  output logic              Meminst,
  output logic              MemWr,
  output logic [ASEL_W-1:0] Asel,
  output logic              Aload,
  output logic              Sub,
  output logic              Halt,
  output logic [STATE_W-1:0] state
);

  state_e state_q, state_d;
  logic   accept_c;

  // Operator Enter: only a fresh press counts, so a held key is ignored.
  edge_detect u_enter_edge (
    .clk    (clk),
    .clear  (clear),
    .level  (Enter),
    .rise_c (accept_c)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = exec_state(IR75);
      S_INPUT:  if (accept_c) state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      S_LOAD, S_STORE, S_ADD, S_SUB, S_JZ, S_JPOS: state_d = S_FETCH;
      default:  state_d = S_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) state_q <= S_START;
    else       state_q <= state_d;
  end

  always_comb begin
    IRload  = 1'b0;
    JMPmux  = 1'b0;
    PCload  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Asel    = ASEL_ALU;
    Aload   = 1'b0;
    Sub     = 1'b0;
    Halt    = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRload = 1'b1;
        PCload = 1'b1;
      end
      S_DECODE: Meminst = 1'b1;
      S_LOAD: begin
        Meminst = 1'b1;
        Asel    = ASEL_RAM;
        Aload   = 1'b1;
      end
      S_STORE: begin
        Meminst = 1'b1;
        MemWr   = 1'b1;
      end
      S_ADD: begin
        Meminst = 1'b1;
        Asel    = ASEL_ALU;
        Aload   = 1'b1;
      end
      S_SUB: begin
        Meminst = 1'b1;
        Asel    = ASEL_ALU;
        Aload   = 1'b1;
        Sub     = 1'b1;
      end
      S_INPUT: begin
        Asel  = ASEL_IN;
        Aload = accept_c;
      end
      S_JZ: begin
        JMPmux = 1'b1;
        PCload = Aeq0;
      end
      S_JPOS: begin
        JMPmux = 1'b1;
        PCload = Apos;
      end
      S_HALT:  Halt = 1'b1;
      default: ;
    endcase
  end

  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus a random run,
// all compared against an instruction-level model of the controller.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       clear, Aeq0, Apos, Enter;
  logic [2:0] IR75;
  logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt;
  logic [1:0] Asel;
  logic [3:0] state;

  int n_vec = 0;
  int n_err = 0;

  // Model: phase 0=start 1=fetch 2=decode 3=execute, opcode latched at decode,
  // plus the last two Enter samples taken at clock edges.
  int         m_phase = 0;
  logic [2:0] m_op    = 3'd0;
  logic       m_e1    = 1'b0;
  logic       m_e2    = 1'b0;

  control_unit dut (
    .clk(clk), .clear(clear), .IR75(IR75), .Aeq0(Aeq0), .Apos(Apos),
    .Enter(Enter), .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload),
    .Meminst(Meminst), .MemWr(MemWr), .Asel(Asel), .Aload(Aload), .Sub(Sub),
    .Halt(Halt), .state(state)
  );

  always #5 clk = ~clk;

  // Vector layout: state[13:10] IRload JMPmux PCload Meminst MemWr Asel[4:3] Aload Sub Halt
  function automatic logic [13:0] obs();
    return {state, IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, Halt};
  endfunction

  function automatic logic [13:0] exp_vec();
    logic [9:0] c;
    logic [3:0] s;
    logic       acc;
    c   = 10'd0;
    s   = 4'd0;
    acc = m_e1 & ~m_e2;
    case (m_phase)
      0: s = 4'd0;
      1: begin s = 4'd1; c[9] = 1'b1; c[7] = 1'b1; end
      2: begin s = 4'd2; c[6] = 1'b1; end
      default: begin
        s = 4'd8 + 4'(m_op);
        case (m_op)
          3'd0: begin c[6] = 1'b1; c[4:3] = 2'd2; c[2] = 1'b1; end
          3'd1: begin c[6] = 1'b1; c[5] = 1'b1; end
          3'd2: begin c[6] = 1'b1; c[2] = 1'b1; end
          3'd3: begin c[6] = 1'b1; c[2] = 1'b1; c[1] = 1'b1; end
          3'd4: begin c[4:3] = 2'd1; c[2] = acc; end
          3'd5: begin c[8] = 1'b1; c[7] = Aeq0; end
          3'd6: begin c[8] = 1'b1; c[7] = Apos; end
          default: c[0] = 1'b1;
        endcase
      end
    endcase
    return {s, c};
  endfunction

  // Advance one clock edge, updating the model from the inputs seen at the edge.
  task automatic tick();
    logic acc, c_clear, c_enter;
    logic [2:0] c_op;
    if (m_phase == 2 && !clear) begin
      n_vec++;
      if ($isunknown(IR75)) begin
        n_err++;
        $display("FAIL decode_ir75: IR75=%b in decode, required a known opcode", IR75);
      end
    end
    acc     = m_e1 & ~m_e2;
    c_clear = clear;
    c_enter = Enter;
    c_op    = IR75;
    @(posedge clk);
    if (c_clear) begin
      m_phase = 0;
      m_e1    = 1'b0;
      m_e2    = 1'b0;
    end else begin
      case (m_phase)
        0: m_phase = 1;
        1: m_phase = 2;
        2: begin m_phase = 3; m_op = c_op; end
        default: begin
          if (m_op == 3'd4) m_phase = acc ? 1 : 3;
          else if (m_op != 3'd7) m_phase = 1;
        end
      endcase
      m_e2 = m_e1;
      m_e1 = c_enter;
    end
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      if (obs() !== 14'd0) begin
        n_err++;
        $display("FAIL reset_%0d: got %b, required %b", i, obs(), 14'd0);
      end
      n_vec++;
    end
    clear = 1'b0;
    tick(); #1;
    if (obs() !== {4'b0001, 10'b1010000000}) begin
      n_err++;
      $display("FAIL boot_fetch: got %b, required %b", obs(), {4'b0001, 10'b1010000000});
    end
    n_vec++;
    tick(); #1;
    if (obs() !== {4'b0010, 10'b0001000000}) begin
      n_err++;
      $display("FAIL boot_decode: got %b, required %b", obs(), {4'b0010, 10'b0001000000});
    end
    n_vec++;
  endtask

  task automatic test_alu();
    logic [2:0] ops [3];
    ops[0] = 3'd0; ops[1] = 3'd2; ops[2] = 3'd3;
    for (int k = 0; k < 3; k++) begin
      IR75 = ops[k];
      for (int i = 0; i < 3; i++) begin
        tick(); #1;
        if (obs() !== exp_vec()) begin
          n_err++;
          $display("FAIL alu_op%0d_cyc%0d: got %b, required %b", ops[k], i, obs(), exp_vec());
        end
        n_vec++;
      end
    end
  endtask

  task automatic test_input();
    Enter = 1'b1;
    IR75  = 3'd1;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      if (obs() !== exp_vec()) begin
        n_err++;
        $display("FAIL input_pre_cyc%0d: got %b, required %b", i, obs(), exp_vec());
      end
      n_vec++;
    end
    IR75 = 3'd4;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      if (state !== 4'b1100 || Aload !== 1'b0 || obs() !== exp_vec()) begin
        n_err++;
        $display("FAIL input_held_cyc%0d: got %b, required %b", i, obs(), exp_vec());
      end
      n_vec++;
    end
    Enter = 1'b0;
    tick(); #1;
    tick();
    Enter = 1'b1;
    #1;
    if (state !== 4'b1100 || Aload !== 1'b0) begin
      n_err++;
      $display("FAIL input_release: state=%b Aload=%b, required 1100 0", state, Aload);
    end
    n_vec++;
    tick(); #1;
    if (obs() !== {4'b1100, 10'b0000001100} || obs() !== exp_vec()) begin
      n_err++;
      $display("FAIL input_accept: got %b, required %b", obs(), {4'b1100, 10'b0000001100});
    end
    n_vec++;
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      if (obs() !== exp_vec()) begin
        n_err++;
        $display("FAIL input_post_cyc%0d: got %b, required %b", i, obs(), exp_vec());
      end
      n_vec++;
    end
  endtask

  task automatic test_jumps();
    logic pattern [4];
    pattern[0] = 1'b1; pattern[1] = 1'b0; pattern[2] = 1'b1; pattern[3] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      IR75 = (k == 0) ? 3'd5 : 3'd6;
      Aeq0 = 1'b1;
      Apos = 1'b0;
      tick();
      for (int j = 0; j < 4; j++) begin
        if (k == 0) Aeq0 = pattern[j];
        else        Apos = pattern[j];
        #1;
        if (PCload !== pattern[j] || JMPmux !== 1'b1 || obs() !== exp_vec()) begin
          n_err++;
          $display("FAIL jump_op%0d_flag%0d: got %b, required %b", IR75, pattern[j], obs(), exp_vec());
        end
        n_vec++;
      end
      for (int i = 0; i < 2; i++) begin
        tick(); #1;
        if (obs() !== exp_vec()) begin
          n_err++;
          $display("FAIL jump_post_cyc%0d: got %b, required %b", i, obs(), exp_vec());
        end
        n_vec++;
      end
    end
  endtask

  task automatic test_halt();
    IR75 = 3'd7;
    for (int i = 0; i < 21; i++) begin
      tick();
      Enter = 1'($urandom_range(0, 1));
      Aeq0  = 1'($urandom_range(0, 1));
      Apos  = 1'($urandom_range(0, 1));
      IR75  = 3'($urandom_range(0, 7));
      #1;
      if (state !== 4'b1111 || Halt !== 1'b1 || obs() !== exp_vec()) begin
        n_err++;
        $display("FAIL halt_cyc%0d: got %b, required %b", i, obs(), exp_vec());
      end
      n_vec++;
    end
    clear = 1'b1;
    tick(); #1;
    if (obs() !== 14'd0) begin
      n_err++;
      $display("FAIL halt_clear: got %b, required %b", obs(), 14'd0);
    end
    n_vec++;
    clear = 1'b0;
    tick(); tick(); #1;
    if (obs() !== exp_vec()) begin
      n_err++;
      $display("FAIL halt_reboot: got %b, required %b", obs(), exp_vec());
    end
    n_vec++;
  endtask

  task automatic test_reset_midop();
    Enter = 1'b0;
    IR75  = 3'd4;
    tick(); #1;
    clear = 1'b1;
    Enter = 1'b1;
    #1;
    if (state !== 4'b1100 || Aload !== 1'b0) begin
      n_err++;
      $display("FAIL midop_input: state=%b Aload=%b, required 1100 0", state, Aload);
    end
    n_vec++;
    tick(); #1;
    if (obs() !== 14'd0) begin
      n_err++;
      $display("FAIL midop_input_clear: got %b, required %b", obs(), 14'd0);
    end
    n_vec++;
    clear = 1'b0;
    tick(); tick();
    IR75 = 3'd1;
    tick(); #1;
    if (MemWr !== 1'b1 || obs() !== exp_vec()) begin
      n_err++;
      $display("FAIL midop_store: got %b, required %b", obs(), exp_vec());
    end
    n_vec++;
    clear = 1'b1;
    tick(); #1;
    if (obs() !== 14'd0 || MemWr !== 1'b0 || Aload !== 1'b0) begin
      n_err++;
      $display("FAIL midop_store_clear: got %b, required %b", obs(), 14'd0);
    end
    n_vec++;
    clear = 1'b0;
    tick(); tick(); #1;
    if (obs() !== exp_vec()) begin
      n_err++;
      $display("FAIL midop_reboot: got %b, required %b", obs(), exp_vec());
    end
    n_vec++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      tick();
      if (m_phase == 3 && m_op == 3'd7) clear = ($urandom_range(0, 3) == 0);
      else                              clear = ($urandom_range(0, 39) == 0);
      IR75  = 3'($urandom_range(0, 7));
      Enter = 1'($urandom_range(0, 1));
      Aeq0  = 1'($urandom_range(0, 1));
      Apos  = 1'($urandom_range(0, 1));
      #1;
      if (obs() !== exp_vec()) begin
        n_err++;
        $display("FAIL random_cyc%0d: got %b, required %b", i, obs(), exp_vec());
      end
      n_vec++;
    end
  endtask

  initial begin
    clear = 1'b1;
    IR75  = 3'd0;
    Aeq0  = 1'b0;
    Apos  = 1'b0;
    Enter = 1'b0;
    test_reset();
    test_alu();
    test_input();
    test_jumps();
    test_halt();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
